// File: rtl/line_buffer_if.sv
// Pixel-in / column-out handshake bundle for line_buffer.
// The slave modport is the line buffer's view; master is the source/sink side.
interface line_buffer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINE_WIDTH = 800,
    parameter int unsigned LINE_COUNT = 3
) ();
    // Input pixel stream
    logic                               in_valid_i;
    logic                               in_ready_o;
    logic [DATA_WIDTH-1:0]              in_data_i;
    logic                               in_start_of_frame_i;

    // Output column stream
    logic                               out_valid_o;
    logic                               out_ready_i;
    logic [LINE_COUNT*DATA_WIDTH-1:0]   out_column_o;
    logic [LINE_COUNT-1:0]              out_rows_valid_o;
    logic [$clog2(LINE_WIDTH)-1:0]      out_x_o;
    logic                               out_end_of_line_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  in_start_of_frame_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_column_o,
        output out_rows_valid_o,
        output out_x_o,
        output out_end_of_line_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output in_start_of_frame_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_column_o,
        input  out_rows_valid_o,
        input  out_x_o,
        input  out_end_of_line_o
    );
endinterface

// File: rtl/line_buffer.sv
// Multi-line video line buffer. Keeps the last LINE_COUNT-1 lines in
// read-first block RAM banks and, for each accepted pixel, emits the vertical
// column of LINE_COUNT pixels at that x position. Rows not yet filled in the
// current frame are masked to zero.
module line_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINE_WIDTH = 800,
    parameter int unsigned LINE_COUNT = 3
) (
    input  logic         clock_i,
    input  logic         reset_i,
    line_buffer_if.slave bus
);
    localparam int unsigned ColumnBits = $clog2(LINE_WIDTH);
    localparam int unsigned NumBanks   = LINE_COUNT - 1;
    localparam int unsigned BankBits   = (NumBanks > 1) ? $clog2(NumBanks) : 1;
    localparam int unsigned FillBits   = $clog2(LINE_COUNT);

    localparam logic [ColumnBits-1:0] LastX    = ColumnBits'(LINE_WIDTH - 1);
    localparam logic [BankBits-1:0]   LastBank = BankBits'(NumBanks - 1);
    localparam logic [FillBits-1:0]   FullFill = FillBits'(NumBanks);

    // Raster position and line-history state
    logic [ColumnBits-1:0]  x_q, x_d;
    logic [BankBits-1:0]    oldest_q, oldest_d;
    logic [FillBits-1:0]    fill_q, fill_d;

    // Output stage
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  pix_q, pix_d;
    logic [BankBits-1:0]    col_bank_q, col_bank_d;
    logic [LINE_COUNT-1:0]  mask_q, mask_d;
    logic [ColumnBits-1:0]  out_x_q, out_x_d;
    logic                   eol_q, eol_d;

    // Handshake and effective (start-of-frame adjusted) position
    logic                   in_ready;
    logic                   accept;
    logic [ColumnBits-1:0]  x_eff;
    logic [FillBits-1:0]    fill_eff;

    logic [NumBanks-1:0][DATA_WIDTH-1:0] bank_rd;
    logic [LINE_COUNT*DATA_WIDTH-1:0]    column;

    // Accept whenever the output register is empty or being drained this cycle
    always_comb begin
        in_ready = !out_valid_q || bus.out_ready_i;
        accept   = bus.in_valid_i && in_ready;
        x_eff    = bus.in_start_of_frame_i ? '0 : x_q;
        fill_eff = bus.in_start_of_frame_i ? '0 : fill_q;
    end

    // Next-state: advance raster counters and load the output stage on acceptance
    always_comb begin
        x_d         = x_q;
        oldest_d    = oldest_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        pix_d       = pix_q;
        col_bank_d  = col_bank_q;
        mask_d      = mask_q;
        out_x_d     = out_x_q;
        eol_d       = eol_q;

        if (accept) begin
            out_valid_d = 1'b1;
            pix_d       = bus.in_data_i;
            col_bank_d  = oldest_q;
            out_x_d     = x_eff;
            eol_d       = (x_eff == LastX);
            for (int unsigned k = 0; k < LINE_COUNT; k++) begin
                mask_d[k] = (k <= 32'(fill_eff));
            end

            if (x_eff == LastX) begin
                x_d      = '0;
                oldest_d = (oldest_q == LastBank) ? '0 : oldest_q + 1'b1;
                fill_d   = (fill_eff == FullFill) ? fill_eff : fill_eff + 1'b1;
            end else begin
                // Start-of-frame mid-line restarts at x=0 with no stored lines,
                // leaving the bank pointer where it was.
                x_d    = x_eff + 1'b1;
                fill_d = fill_eff;
            end
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output-stage registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            x_q         <= '0;
            oldest_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            pix_q       <= '0;
            col_bank_q  <= '0;
            mask_q      <= '0;
            out_x_q     <= '0;
            eol_q       <= 1'b0;
        end else begin
            x_q         <= x_d;
            oldest_q    <= oldest_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            pix_q       <= pix_d;
            col_bank_q  <= col_bank_d;
            mask_q      <= mask_d;
            out_x_q     <= out_x_d;
            eol_q       <= eol_d;
        end
    end

    // Line banks: simple dual-port, read-first; read register holds during stalls
    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [LINE_WIDTH];
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  wr_en;

        assign wr_en      = accept && (oldest_q == BankBits'(b));
        assign bank_rd[b] = rd_q;

        // Registered read of the addressed pixel and write of the incoming one
        always_ff @(posedge clock_i) begin
            if (accept) begin
                rd_q <= mem[x_eff];
            end
            if (wr_en) begin
                mem[x_eff] <= bus.in_data_i;
            end
        end
    end

    // Column assembly: map each row to its bank and zero rows not yet filled
    always_comb begin
        int unsigned idx;
        column = '0;
        idx    = 0;
        column[0 +: DATA_WIDTH] = pix_q;
        for (int unsigned k = 1; k < LINE_COUNT; k++) begin
            idx = 32'(col_bank_q) + NumBanks - k;
            if (idx >= NumBanks) begin
                idx = idx - NumBanks;
            end
            if (mask_q[k]) begin
                column[k*DATA_WIDTH +: DATA_WIDTH] = bank_rd[BankBits'(idx)];
            end
        end
    end

    assign bus.in_ready_o        = in_ready;
    assign bus.out_valid_o       = out_valid_q;
    assign bus.out_column_o      = column;
    assign bus.out_rows_valid_o  = mask_q;
    assign bus.out_x_o           = out_x_q;
    assign bus.out_end_of_line_o = eol_q;
endmodule

// File: tb/tb_line_buffer.sv
// Testbench for line_buffer with LINE_WIDTH=4, LINE_COUNT=3, pixel = 16*row+col.
module tb_line_buffer;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned LC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_buffer_if #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .LINE_COUNT(LC)) bus ();

    line_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .LINE_COUNT(LC)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [23:0] column;
        logic [2:0]  mask;
        logic [1:0]  x;
        logic        eol;
        int          row;
    } exp_t;

    typedef struct {
        int          row;
        int          col;
        logic [23:0] column;
        logic [2:0]  mask;
        logic        eol;
    } spot_t;

    typedef struct {
        logic       v;
        logic       sof;
        logic [7:0] d;
        logic       rdy;
    } vec_t;

    exp_t  sb[$];
    spot_t spots[6];
    vec_t  vecs[$];

    int tests = 0;
    int fails = 0;
    bit spot_en = 1'b0;

    // Reference model: history of complete lines, most recent first
    int         mx, mfill, mrow;
    logic [7:0] cur   [LW];
    logic [7:0] lines [2][LW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] d, input logic sof);
        exp_t e;
        if (sof) begin
            mx = 0; mfill = 0; mrow = 0;
        end
        e.column = {16'h0, d};
        e.mask   = 3'b001;
        for (int k = 1; k < 3; k++) begin
            if (k <= mfill) begin
                e.column[k*8 +: 8] = lines[k-1][mx];
                e.mask[k] = 1'b1;
            end
        end
        e.x   = 2'(mx);
        e.eol = (mx == LW - 1);
        e.row = mrow;
        sb.push_back(e);
        cur[mx] = d;
        if (mx == LW - 1) begin
            lines[1] = lines[0];
            lines[0] = cur;
            if (mfill < 2) mfill++;
            mx = 0;
            mrow++;
        end else begin
            mx++;
        end
    endtask

    task automatic sample(input logic v, input logic sof, input logic [7:0] d, input logic rdy);
        bit   have;
        exp_t e;
        have = (sb.size() > 0);
        check("out_valid", 32'(bus.out_valid_o), 32'(have));
        check("in_ready", 32'(bus.in_ready_o), 32'(!have || rdy));
        if (have) begin
            e = sb[0];
            check($sformatf("column r%0d x%0d", e.row, e.x), 32'(bus.out_column_o), 32'(e.column));
            check($sformatf("mask r%0d x%0d", e.row, e.x), 32'(bus.out_rows_valid_o), 32'(e.mask));
            check($sformatf("x r%0d", e.row), 32'(bus.out_x_o), 32'(e.x));
            check($sformatf("eol r%0d x%0d", e.row, e.x), 32'(bus.out_end_of_line_o), 32'(e.eol));
            if (spot_en) begin
                foreach (spots[i]) begin
                    if (spots[i].row == e.row && spots[i].col == int'(e.x)) begin
                        check($sformatf("spot column r%0d x%0d", e.row, e.x),
                              32'(bus.out_column_o), 32'(spots[i].column));
                        check($sformatf("spot mask r%0d x%0d", e.row, e.x),
                              32'(bus.out_rows_valid_o), 32'(spots[i].mask));
                        check($sformatf("spot eol r%0d x%0d", e.row, e.x),
                              32'(bus.out_end_of_line_o), 32'(spots[i].eol));
                    end
                end
            end
            if (rdy) void'(sb.pop_front());
        end
        if (v && (!have || rdy)) model_accept(d, sof);
    endtask

    task automatic cyc(input logic v, input logic sof, input logic [7:0] d, input logic rdy);
        bus.in_valid_i          = v;
        bus.in_start_of_frame_i = sof;
        bus.in_data_i           = d;
        bus.out_ready_i         = rdy;
        @(negedge clk);
        sample(v, sof, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid_i          = 1'b0;
        bus.in_start_of_frame_i = 1'b0;
        bus.in_data_i           = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        sb.delete();
        mx = 0; mfill = 0; mrow = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"}, 32'(bus.out_valid_o), 32'(0));
        check({tag, " column"}, 32'(bus.out_column_o), 32'(0));
        check({tag, " mask"}, 32'(bus.out_rows_valid_o), 32'(0));
        check({tag, " x"}, 32'(bus.out_x_o), 32'(0));
        check({tag, " eol"}, 32'(bus.out_end_of_line_o), 32'(0));
        check({tag, " in_ready"}, 32'(bus.in_ready_o), 32'(1));
    endtask

    task automatic stream(input int nlines, input bit sparse);
        for (int r = 0; r < nlines; r++) begin
            for (int c = 0; c < int'(LW); c++) begin
                cyc(1'b1, (r == 0 && c == 0), 8'(16 * r + c), 1'b1);
                if (sparse) begin
                    cyc(1'b0, 1'b0, 8'h00, 1'b1);
                    cyc(1'b0, 1'b0, 8'h00, 1'b1);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid_i          = 1'b0;
        bus.in_start_of_frame_i = 1'b0;
        bus.in_data_i           = '0;
        bus.out_ready_i         = 1'b1;
        mx = 0; mfill = 0; mrow = 0;

        spots[0] = '{row: 0, col: 0, column: 24'h000000, mask: 3'b001, eol: 1'b0};
        spots[1] = '{row: 0, col: 3, column: 24'h000003, mask: 3'b001, eol: 1'b1};
        spots[2] = '{row: 1, col: 3, column: 24'h000313, mask: 3'b011, eol: 1'b1};
        spots[3] = '{row: 2, col: 1, column: 24'h011121, mask: 3'b111, eol: 1'b0};
        spots[4] = '{row: 2, col: 3, column: 24'h031323, mask: 3'b111, eol: 1'b1};
        spots[5] = '{row: 5, col: 2, column: 24'h324252, mask: 3'b111, eol: 1'b0};

        // Reset state
        do_reset();
        check_idle("reset");

        // Streamed 6-line frame with a 5-cycle output stall before row 1 col 2
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < int'(LW); c++) begin
                if (r == 1 && c == 2) begin
                    for (int s = 0; s < 5; s++) begin
                        vecs.push_back('{v: 1'b1, sof: 1'b0, d: 8'(16 * r + c), rdy: 1'b0});
                    end
                end
                vecs.push_back('{v: 1'b1, sof: (r == 0 && c == 0), d: 8'(16 * r + c), rdy: 1'b1});
            end
        end
        spot_en = 1'b1;
        foreach (vecs[i]) cyc(vecs[i].v, vecs[i].sof, vecs[i].d, vecs[i].rdy);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Mid-line start-of-frame after two lines plus two pixels
        spot_en = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < int'(LW); c++) begin
                cyc(1'b1, (r == 0 && c == 0), 8'(16 * r + c), 1'b1);
            end
        end
        cyc(1'b1, 1'b0, 8'h20, 1'b1);
        cyc(1'b1, 1'b0, 8'h21, 1'b1);
        cyc(1'b1, 1'b1, 8'hA0, 1'b1);
        check("sof x", 32'(bus.out_x_o), 32'(0));
        check("sof mask", 32'(bus.out_rows_valid_o), 32'(3'b001));
        check("sof column", 32'(bus.out_column_o), 32'(24'h0000A0));
        cyc(1'b1, 1'b0, 8'hA1, 1'b1);
        check("post-sof x", 32'(bus.out_x_o), 32'(1));
        check("post-sof mask", 32'(bus.out_rows_valid_o), 32'(3'b001));
        check("post-sof column", 32'(bus.out_column_o), 32'(24'h0000A1));
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset during row 2 with an output column stalled
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < int'(LW); c++) begin
                cyc(1'b1, (r == 0 && c == 0), 8'(16 * r + c), 1'b1);
            end
        end
        cyc(1'b1, 1'b0, 8'h20, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        do_reset();
        check_idle("mid reset");
        cyc(1'b1, 1'b0, 8'h77, 1'b1);
        check("after reset x", 32'(bus.out_x_o), 32'(0));
        check("after reset mask", 32'(bus.out_rows_valid_o), 32'(3'b001));
        check("after reset column", 32'(bus.out_column_o), 32'(24'h000077));
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Sparse input: one pixel every third cycle
        spot_en = 1'b1;
        stream(3, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/line_buffer.md
# line_buffer

Multi-line video line buffer for the real-time processing pipeline. It stores the most recent `LINE_COUNT-1` lines of a raster pixel stream in internal simple dual-port block RAM banks. For every accepted input pixel it emits a vertical column of `LINE_COUNT` pixels at that x position, with the current pixel plus the pixels directly above it. It sits between the pixel source and the neighbourhood (convolution/filter) stages, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `DATA_WIDTH`, 8, bits per pixel.
- `LINE_WIDTH`, 800, pixels per line; ≥2.
- `LINE_COUNT`, 3, rows in an output column; ≥2. Internal banks = `LINE_COUNT-1`.
- `ColumnBits` (localparam), `$clog2(LINE_WIDTH)`.

Ports:
- `clock_i`, in, 1, sole clock; all logic on its rising edge.
- `reset_i`, in, 1, synchronous, active-high reset.
- `in_valid_i`, in, 1, input pixel valid.
- `in_ready_o`, out, 1, block can accept a pixel this cycle.
- `in_data_i`, in, `DATA_WIDTH`, input pixel.
- `in_start_of_frame_i`, in, 1, qualifies `in_data_i` as pixel (0,0) of a new frame.
- `out_valid_o`, out, 1, output column valid.
- `out_ready_i`, in, 1, downstream accepts the column.
- `out_column_o`, out, `LINE_COUNT*DATA_WIDTH`, slice k (`[k*DATA_WIDTH +: DATA_WIDTH]`) is the pixel k lines above the current one; k=0 is the current pixel.
- `out_rows_valid_o`, out, `LINE_COUNT`, bit k = slice k holds real frame data; bit 0 is always 1 when `out_valid_o` is 1.
- `out_x_o`, out, `ColumnBits`, x position of the column.
- `out_end_of_line_o`, out, 1, `out_x_o == LINE_WIDTH-1`.

## Operation
- An input is accepted when `in_valid_i && in_ready_o`. Then `in_ready_o = !out_valid_o || out_ready_i`.
- State:
  - x counter `x` is 0..`LINE_WIDTH-1`.
  - Bank pointer `oldest` is 0..`LINE_COUNT-2` and names the bank holding the line `LINE_COUNT-1` lines back.
  - Fill count `fill` is 0..`LINE_COUNT-1` and saturates. It counts complete lines stored for the current frame.
- On acceptance at x = `x`:
  - All banks read at address `x` with read enable.
  - `in_data_i` is written into bank `oldest` at address `x`.
  - A same-address read/write collision is read-first: the old content is returned.
  - The pixel, x, end-of-line flag and row-valid mask are registered into the output stage.
- Row mapping: slice k (k≥1) comes from bank `(oldest + LINE_COUNT-1 - k) mod (LINE_COUNT-1)`, using the pointer value at acceptance.
- Row-valid mask: bit k = (k ≤ `fill`). Slices with bit clear output all zeros; stale RAM contents are never exposed.
- After acceptance with `x == LINE_WIDTH-1`:
  - `x` becomes 0.
  - `oldest` becomes `(oldest+1) mod (LINE_COUNT-1)`.
  - `fill` becomes `min(fill+1, LINE_COUNT-1)`.
- Otherwise `x` increments.
- When `in_start_of_frame_i` is set on an accepted pixel:
  - That pixel is treated as x=0 with `fill`=0, so only row 0 is valid.
  - This applies mid-line: the partial line is discarded and `oldest` is unchanged.
  - Counters then advance from x=0 as normal.
- `in_start_of_frame_i` without acceptance is ignored.
- During a stall (`out_valid_o && !out_ready_i`):
  - RAM read enables are low and no write occurs.
  - All outputs hold stable.
- Reset:
  - `out_valid_o`=0, `out_column_o`=0, `out_rows_valid_o`=0, `out_x_o`=0, `out_end_of_line_o`=0.
  - `x`=0, `oldest`=0, `fill`=0.
  - `in_ready_o`=1 in the cycle after reset deasserts.
  - RAM contents are not cleared; they are masked by `fill`=0.
  - Reset mid-line or mid-stall discards the in-flight column.

## Timing
- Latency: a pixel accepted in cycle n appears on the outputs with `out_valid_o`=1 in cycle n+1.
- Throughput: one pixel per cycle with `out_ready_i` held high.
- `out_valid_o` falls in the cycle after a transfer that has no new acceptance.
- Simultaneous output transfer and input acceptance in the same cycle is legal and gives back-to-back columns.
- No combinational path from `in_valid_i` to `in_ready_o`. `out_ready_i` reaches `in_ready_o` combinationally.

## Test plan
All scenarios use `LINE_WIDTH`=4, `LINE_COUNT`=3 and pixel value = 16·row + col.
- **Reset, then a streamed 4×4 frame** (start-of-frame on the first pixel, `out_ready_i`=1):
  - Row 0 columns give `out_rows_valid_o`=001 and slices (c,0,0).
  - Row 2 col 1 gives the column (0x21, 0x11, 0x01) with mask 111.
  - `out_end_of_line_o`=1 at x=3 only.
- **Backpressure:** hold `out_ready_i`=0 for 5 cycles mid-row 1.
  - `in_ready_o`=0 throughout the stall.
  - Outputs are held stable.
  - No pixel is lost or duplicated once the stall releases.
- **Bank wrap:** stream 6 lines.
  - Row 5 col 2 gives (0x52, 0x42, 0x32).
  - This confirms the pointer rotation through both banks over ≥2 wraps.
- **Mid-line start-of-frame:** after 2 lines plus 2 pixels, assert start-of-frame with value 0xA0.
  - Output is x=0, mask 001, slices (0xA0, 0, 0).
  - The next pixel appears at x=1.
- **Reset mid-operation:** assert `reset_i` for 1 cycle during row 2 with an output stalled.
  - All outputs go to 0 the next cycle.
  - The following pixel gives mask 001 and x=0.
- **Sparse input:** drive `in_valid_i` every third cycle.
  - Each column appears exactly 1 cycle after its acceptance.
  - Column data matches the streamed-frame scenario.
